dmem_line_ctrl: RTL and testbench
=================================

DMEM_LINE_CTRL -- requirements
Module: dmem_line_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 10, meaning the number of clock edges from request acceptance to ack; legal range 1..255.
REQ-002 SHALL have parameter LINE_BITS, default 9, meaning log2 of the number of 256-bit lines stored (512 lines, 16 KiB).
REQ-003 SHALL have port clk_i, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port addr_i, input, 32 bits: byte address of the line; bits [4:0] ignored.
REQ-006 SHALL have port data_i, input, 256 bits: write line data.
REQ-007 SHALL have port enable_i, input, 1 bit: request valid, held high by the requester until ack.
REQ-008 SHALL have port write_i, input, 1 bit: 1 = line write, 0 = line read.
REQ-009 SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port data_o, output, 256 bits: read line data.
REQ-011 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement a three-state FSM:
- IDLE: the only state that accepts requests.
- WAIT: counting latency.
- ACK: completion cycle.
REQ-013 SHALL accept a request on a rising edge where state = IDLE and enable_i = 1, and latch at that edge:
- line index = addr_i[LINE_BITS+4:5]
- write_i
- data_i
REQ-014 SHALL ignore addr_i bits above LINE_BITS+4, so out-of-range addresses alias modulo the array size.
REQ-015 SHALL load a cycle counter with 1 on acceptance.
- LATENCY = 1: go directly IDLE -> ACK.
- Otherwise: go IDLE -> WAIT, increment the counter on each WAIT edge, and go WAIT -> ACK on the edge where counter = LATENCY-1.
REQ-016 SHALL assert ack_o during exactly the cycle that begins at acceptance edge + LATENCY, for exactly one cycle.
REQ-017 SHALL, on a latched write, commit the latched data to the latched line on the edge entering ACK.
REQ-018 SHALL, on a latched read, register the latched line into data_o on the edge entering ACK, so data_o is valid while ack_o = 1.
REQ-019 SHALL hold data_o unchanged after a read until the next read enters ACK; writes SHALL NOT change data_o.
REQ-020 SHALL transition ACK -> IDLE unconditionally on the next edge.
- No request is accepted in ACK, because the requester still drives enable_i high during the ack cycle.
REQ-021 SHALL accept a back-to-back request held on enable_i (write-back then refill with enable_i never dropping) at the first edge in IDLE, i.e. acceptance edge + LATENCY + 1.
REQ-022 SHALL ignore changes to addr_i, data_i and write_i while in WAIT or ACK; the latched values govern the transaction.
REQ-023 SHALL complete an accepted transaction even if enable_i drops mid-transaction; abort is not supported.
REQ-024 SHALL use a read-after-write to the same line that returns the data written by the earlier transaction.

Reset
REQ-025 SHALL, while rst_i = 0, force state = IDLE, counter = 0, ack_o = 0, busy_o = 0 and data_o = 0, irrespective of clock.
REQ-026 SHALL, on reset mid-transaction, drop the pending transaction with no write committed and no ack issued.
REQ-027 SHALL NOT reset the storage array; contents persist across reset, and the bench preloads them via hierarchical access.

Verification
REQ-028 SHALL cover a read with LATENCY = 10: line 3 preloaded with pattern P; enable_i=1, write_i=0, addr_i=0x0000_0060 accepted at edge 0 -> ack_o high only in the cycle after edge 10, data_o = P.
REQ-029 SHALL cover write then read: write 256'hA5..A5 to addr 0x0000_0400 -> ack after 10 edges; read of the same addr -> data_o = 256'hA5..A5, and data_o is unchanged during the write.
REQ-030 SHALL cover write-back then refill with enable_i held high:
- write to 0x0000_0020, then write_i drops to 0 with addr 0x0000_0040 in the cycle after ack.
- Required: second acceptance at edge 11, second ack in the cycle after edge 21, line 1 updated, data_o = line 2.
REQ-031 SHALL cover LATENCY = 1: a read is accepted at edge 0 -> ack_o high in the cycle after edge 1 with correct data, and busy_o is high for 1 cycle only.
REQ-032 SHALL cover aliasing: a write to 0x0000_4020 (LINE_BITS = 9) followed by a read from 0x0000_0020 returns the written data.
REQ-033 SHALL cover reset mid-transaction: rst_i = 0 asserted at edge 5 of a write -> ack_o never pulses, busy_o = 0 immediately, and a subsequent read of that line returns the old data.

Source files
------------

// File: rtl/dmem_line_ctrl.sv
// Line-wide data memory controller: one 256-bit line per request, fixed
// LATENCY from acceptance to a one-cycle ack, with write commit / read capture at the ACK state.
module dmem_line_ctrl #(
  parameter int LATENCY   = 10,
  parameter int LINE_BITS = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o
);

  localparam int         DEPTH  = 1 << LINE_BITS;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic                   r_ack;
  logic                   r_busy;
  logic [255:0]           r_data_o;
  logic [LINE_BITS-1:0]   r_line;
  logic                   r_write;
  logic [255:0]           r_wdata;
  logic [255:0]           r_mem [0:DEPTH-1];

  logic                   w_accept;
  logic                   w_enter_ack;
  logic [LINE_BITS-1:0]   w_line;
  logic                   w_write;
  logic [255:0]           w_wdata;
  logic                   w_unused;

  // With LATENCY = 1 the ACK state is entered on the acceptance edge itself,
  // so the live request fields must be used instead of the latched copies.
  assign w_accept    = rst_i && (r_state == S_IDLE) && enable_i;
  assign w_enter_ack = (w_accept && (LATENCY == 1)) ||
                       ((r_state == S_WAIT) && (r_cnt == LAT_M1));
  assign w_line      = (r_state == S_IDLE) ? addr_i[LINE_BITS+4:5] : r_line;
  assign w_write     = (r_state == S_IDLE) ? write_i : r_write;
  assign w_wdata     = (r_state == S_IDLE) ? data_i : r_wdata;
  assign w_unused    = ^{addr_i[31:LINE_BITS+5], addr_i[4:0]};

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (w_enter_ack && w_write) begin
      r_mem[w_line] <= w_wdata;
    end
  end

  // ack_o is a registered copy of the ACK state, so it trails the state by
  // one cycle and lands exactly LATENCY edges after acceptance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_data_o <= '0;
      r_line   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
    end else begin
      r_ack <= (r_state == S_ACK);
      if (w_enter_ack && !w_write) begin
        r_data_o <= r_mem[w_line];
      end
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_line  <= addr_i[LINE_BITS+4:5];
            r_write <= write_i;
            r_wdata <= data_i;
            r_cnt   <= 8'd1;
            r_busy  <= 1'b1;
            r_state <= (LATENCY == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAT_M1) begin
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o  = r_ack;
  assign busy_o = r_busy;
  assign data_o = r_data_o;

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Scoreboard bench for dmem_line_ctrl: one instance at LATENCY=10, one at LATENCY=1,
// directed line reads/writes with hand-picked expected data and ack cycles.
module tb_dmem_line_ctrl;

  typedef struct {
    int           id;
    int           ack_cyc;
    logic [255:0] data;
  } exp_t;

  localparam logic [255:0] P  = {8{32'h0123_4567}};
  localparam logic [255:0] Q2 = {8{32'h2222_2222}};
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] W1 = {8{32'h1111_0001}};
  localparam logic [255:0] W2 = {8{32'h4020_4020}};
  localparam logic [255:0] W3 = {8{32'hBAD0_BAD0}};
  localparam logic [255:0] R5 = {8{32'h5555_AAAA}};
  localparam logic [255:0] W4 = {8{32'hC0C0_0006}};

  logic         clk;
  logic         rst;
  logic [31:0]  addr  [2];
  logic [255:0] wdata [2];
  logic         en    [2];
  logic         wr    [2];
  logic         ack   [2];
  logic [255:0] rdata [2];
  logic         busy  [2];

  logic [255:0] model [2];
  exp_t         sbq [$];
  int           cyc;
  int           errors;
  int           checks;

  dmem_line_ctrl #(.LATENCY(10), .LINE_BITS(9)) dut0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0]), .data_i(wdata[0]),
    .enable_i(en[0]), .write_i(wr[0]), .ack_o(ack[0]), .data_o(rdata[0]), .busy_o(busy[0])
  );

  dmem_line_ctrl #(.LATENCY(1), .LINE_BITS(9)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[1]), .data_i(wdata[1]),
    .enable_i(en[1]), .write_i(wr[1]), .ack_o(ack[1]), .data_o(rdata[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic int lat(input int k);
    return (k == 0) ? 10 : 1;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT pulses ack_o.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ack[k]) begin
          if (sbq.size() == 0 || sbq[0].id != k) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack dut%0d cycle=%0d actual=1 required=0", k, cyc);
          end else begin
            e = sbq.pop_front();
            chk("ack_cycle", 256'(cyc), 256'(e.ack_cyc));
            chk("data_o_at_ack", rdata[k], e.data);
          end
        end else if (sbq.size() != 0 && sbq[0].id == k && cyc > sbq[0].ack_cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_ack dut%0d cycle=%0d actual=0 required=1 at cycle %0d",
                   k, cyc, sbq[0].ack_cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic issue(input int k, input logic [31:0] a, input logic [255:0] d,
                       input logic w, input logic [255:0] exp_rd, input bit push);
    exp_t e;
    addr[k]  = a;
    wdata[k] = d;
    wr[k]    = w;
    en[k]    = 1'b1;
    if (push) begin
      if (!w) model[k] = exp_rd;
      e.id      = k;
      e.ack_cyc = cyc + 1 + lat(k);
      e.data    = model[k];
      sbq.push_back(e);
    end
  endtask

  // Waits for ack, counting busy cycles; scrambles the request fields after
  // acceptance and optionally drops enable mid-transaction.
  task automatic wait_ack(input int k, input bit hold, output int bc);
    int  n;
    bit  done;
    bc   = 0;
    n    = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (ack[k]) begin
        done = 1;
      end else begin
        if (busy[k]) bc++;
        if (n == 0) begin
          addr[k]  = addr[k] ^ 32'h0000_0060;
          wdata[k] = ~wdata[k];
          wr[k]    = ~wr[k];
          if (!hold) en[k] = 1'b0;
        end
        n++;
        if (n > 400) begin
          checks++;
          errors++;
          $display("FAIL ack_timeout dut%0d actual=no_ack required=ack", k);
          done = 1;
        end
      end
    end
  endtask

  task automatic txn(input int k, input logic [31:0] a, input logic [255:0] d,
                     input logic w, input logic [255:0] exp_rd);
    int bc;
    @(negedge clk);
    issue(k, a, d, w, exp_rd, 1'b1);
    wait_ack(k, 1'b0, bc);
    chk("busy_cycles", 256'(bc), 256'(lat(k)));
    en[k] = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bc;
    int e0;
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      addr[k]  = '0;
      wdata[k] = '0;
      en[k]    = 1'b0;
      wr[k]    = 1'b0;
      model[k] = '0;
    end
    dut0.r_mem[3] = P;
    dut0.r_mem[2] = Q2;
    dut1.r_mem[5] = R5;

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ack", 256'(ack[k]), 256'(0));
      chk("reset_busy", 256'(busy[k]), 256'(0));
      chk("reset_data_o", rdata[k], '0);
    end
    rst = 1'b1;

    // Plain read of line 3, then write/read of line 32.
    txn(0, 32'h0000_0060, '0, 1'b0, P);
    txn(0, 32'h0000_0400, A5, 1'b1, '0);
    txn(0, 32'h0000_0400, '0, 1'b0, A5);

    // Write-back then refill with enable held across the ack cycle.
    @(negedge clk);
    issue(0, 32'h0000_0020, W1, 1'b1, '0, 1'b1);
    wait_ack(0, 1'b1, bc);
    chk("busy_cycles_wb", 256'(bc), 256'(10));
    issue(0, 32'h0000_0040, '0, 1'b0, Q2, 1'b1);
    wait_ack(0, 1'b1, bc);
    chk("busy_cycles_refill", 256'(bc), 256'(10));
    en[0] = 1'b0;
    txn(0, 32'h0000_0020, '0, 1'b0, W1);

    // Aliasing: 0x4020 maps onto line 1.
    txn(0, 32'h0000_4020, W2, 1'b1, '0);
    txn(0, 32'h0000_0020, '0, 1'b0, W2);

    // Reset at the fifth edge of a write: nothing committed, no ack.
    @(negedge clk);
    issue(0, 32'h0000_0020, W3, 1'b1, '0, 1'b0);
    e0 = cyc + 1;
    while (cyc != e0 + 4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_busy_now", 256'(busy[0]), 256'(0));
    chk("rst_ack_now", 256'(ack[0]), 256'(0));
    chk("rst_data_o_now", rdata[0], '0);
    repeat (12) begin
      @(negedge clk);
      chk("rst_hold_ack", 256'(ack[0]), 256'(0));
    end
    en[0]    = 1'b0;
    model[0] = '0;
    model[1] = '0;
    @(negedge clk);
    rst = 1'b1;
    txn(0, 32'h0000_0020, '0, 1'b0, W2);

    // LATENCY = 1 instance.
    txn(1, 32'h0000_00A0, '0, 1'b0, R5);
    txn(1, 32'h0000_00C0, W4, 1'b1, '0);
    txn(1, 32'h0000_00C0, '0, 1'b0, W4);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 256'(sbq.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
